// File: rtl/alu_seq_w.sv
// alu_seq_w: registered W-bit ALU with valid/ready handshakes on both sides
// and an internal {C,Z,N,V} flags register. ADC/SBB take carry/borrow from
// the stored C flag. The flags update when a result enters DONE, so an op
// issued back-to-back already sees the new C.
//
// Optional feature: define ALU_MUL_EN to build the multi-cycle shift-and-add
// unsigned multiplier (opcode 10). Without it, opcode 10 is illegal and no
// multiplier datapath or MUL_RUN state exists.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   request handshake; op, A, B captured on acceptance
//   out_valid/out_ready result handshake; outputs held while out_ready=0
//   result, result_hi   result (low half for MUL), high half for MUL else 0
//   flags               {C,Z,N,V} after this result
//   err                 illegal opcode for this result
module alu_seq_w #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] op,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic [W-1:0]  result_hi,
  output logic [3:0]    flags,
  output logic          err
);

  localparam logic [CW-1:0] OP_ADD = CW'(0);
  localparam logic [CW-1:0] OP_ADC = CW'(1);
  localparam logic [CW-1:0] OP_SUB = CW'(2);
  localparam logic [CW-1:0] OP_SBB = CW'(3);
  localparam logic [CW-1:0] OP_AND = CW'(4);
  localparam logic [CW-1:0] OP_OR  = CW'(5);
  localparam logic [CW-1:0] OP_XOR = CW'(6);
  localparam logic [CW-1:0] OP_NOT = CW'(7);
  localparam logic [CW-1:0] OP_SHL = CW'(8);
  localparam logic [CW-1:0] OP_SHR = CW'(9);

`ifdef ALU_MUL_EN
  localparam logic [CW-1:0] OP_MUL = CW'(10);
  localparam int CNT_W = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         er;
  } alu_t;

  // Single-cycle ALU evaluation. Arithmetic runs at W+1 bits; bit W is the
  // carry (add) or borrow (subtract). Illegal ops leave flags untouched.
  function automatic alu_t alu_eval(input logic [CW-1:0] f_op,
                                    input logic [W-1:0]  fa,
                                    input logic [W-1:0]  fb,
                                    input logic [3:0]    fl);
    alu_t               r;
    logic [W:0]         ext;
    logic               c;
    logic               v;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic signed [W-1:0] sr;
    r   = '0;
    ext = '0;
    c   = fl[3];
    v   = 1'b0;
    sa  = fa;
    sb  = fb;
    case (f_op)
      OP_ADD, OP_ADC: begin
        ext   = {1'b0, fa} + {1'b0, fb} + {{W{1'b0}}, (f_op == OP_ADC) & fl[3]};
        r.res = ext[W-1:0];
        c     = ext[W];
        sr    = ext[W-1:0];
        v     = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      OP_SUB, OP_SBB: begin
        ext   = {1'b0, fa} - {1'b0, fb} - {{W{1'b0}}, (f_op == OP_SBB) & fl[3]};
        r.res = ext[W-1:0];
        c     = ext[W];
        sr    = ext[W-1:0];
        v     = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
      end
      OP_AND: r.res = fa & fb;
      OP_OR:  r.res = fa | fb;
      OP_XOR: r.res = fa ^ fb;
      OP_NOT: r.res = ~fa;
      OP_SHL: begin
        r.res = {fa[W-2:0], 1'b0};
        c     = fa[W-1];
      end
      OP_SHR: begin
        r.res = {1'b0, fa[W-1:1]};
        c     = fa[0];
      end
      default: r.er = 1'b1;
    endcase
    if (r.er) r.fl = fl;
    else      r.fl = {c, (r.res == '0), r.res[W-1], v};
    return r;
  endfunction

  state_t state, state_n;
  logic   load_single;
  logic   is_mul;
  alu_t   alu_p0;

`ifdef ALU_MUL_EN
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     mcand;
  logic [W:0]       psum;
  logic             load_mul;
  logic             fin_mul;
  assign is_mul = (op == OP_MUL);
  // Add multiplicand to the upper half when the current LSB is set, then
  // shift the whole product right; the carry lands in the top bit.
  assign psum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
`else
  assign is_mul = 1'b0;
`endif

  assign alu_p0    = alu_eval(op, A, B, flags);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    in_ready    = 1'b0;
    load_single = 1'b0;
`ifdef ALU_MUL_EN
    load_mul    = 1'b0;
    fin_mul     = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        in_ready = (state == IDLE) ? 1'b1 : out_ready;
        if (in_ready && in_valid) begin
          if (is_mul) begin
`ifdef ALU_MUL_EN
            load_mul = 1'b1;
            state_n  = MUL_RUN;
`endif
          end else begin
            load_single = 1'b1;
            state_n     = DONE;
          end
        end else if (state == DONE && out_ready) begin
          state_n = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      MUL_RUN: begin
        if (cnt == CNT_W'(W)) begin
          fin_mul = 1'b1;
          state_n = DONE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Result stage: outputs and flags register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else if (load_single) begin
      result    <= alu_p0.res;
      result_hi <= '0;
      flags     <= alu_p0.fl;
      err       <= alu_p0.er;
`ifdef ALU_MUL_EN
    end else if (fin_mul) begin
      result    <= prod[W-1:0];
      result_hi <= prod[2*W-1:W];
      flags     <= {(prod[2*W-1:W] != '0), (prod == '0), prod[W-1], 1'b0};
      err       <= 1'b0;
`endif
    end
  end

`ifdef ALU_MUL_EN
  // Multiplier step counter: W steps, then one cycle to register the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt <= '0;
    else if (load_mul)                          cnt <= '0;
    else if (state == MUL_RUN && cnt != CNT_W'(W)) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load_mul) begin
      prod  <= {{W{1'b0}}, B};
      mcand <= A;
    end else if (state == MUL_RUN && cnt != CNT_W'(W)) begin
      prod  <= {psum, prod[W-1:1]};
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_w.sv
module tb_alu_seq_w;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;
  logic         err;

  alu_seq_w #(.W(W), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    logic         er;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: each result handshake pops the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=none", result);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, ".result"},    32'(result),    32'(mon_e.res));
        chk({mon_e.name, ".result_hi"}, 32'(result_hi), 32'(mon_e.hi));
        chk({mon_e.name, ".flags"},     32'(flags),     32'(mon_e.fl));
        chk({mon_e.name, ".err"},       32'(err),       32'(mon_e.er));
      end
    end
  end

  // Present a request, push its expectation, return at posedge+1 after acceptance
  task automatic issue(input string name, input logic [3:0] o,
                       input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [W-1:0] eres, input logic [W-1:0] ehi,
                       input logic [3:0] efl, input logic eer);
    exp_t e;
    int   n;
    e.name = name; e.res = eres; e.hi = ehi; e.fl = efl; e.er = eer;
    op = o; a = xa; b = xb; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL %s.accept in_ready=%0b required=1", name, in_ready);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result",    32'(result),    32'd0);
    chk("rst.result_hi", 32'(result_hi), 32'd0);
    chk("rst.flags",     32'(flags),     32'd0);
    chk("rst.err",       32'(err),       32'd0);
    rst_n = 1'b1;
    chk("rst.in_ready",  32'(in_ready),  32'd1);

    // Back-to-back arithmetic/logic chain, out_ready held high
    issue("add", 4'd0, 8'h57, 8'hB1, 8'h08, 8'h00, 4'b1000, 1'b0);
    chk("add.latency", 32'(out_valid), 32'd1);
    issue("adc", 4'd1, 8'h57, 8'hB1, 8'h09, 8'h00, 4'b1000, 1'b0);
    issue("sub", 4'd2, 8'h57, 8'hB1, 8'hA6, 8'h00, 4'b1011, 1'b0);
    issue("sbb", 4'd3, 8'h57, 8'hB1, 8'hA5, 8'h00, 4'b1011, 1'b0);
    issue("and", 4'd4, 8'hF1, 8'hB1, 8'hB1, 8'h00, 4'b1010, 1'b0);
    issue("or",  4'd5, 8'hF1, 8'hB1, 8'hF1, 8'h00, 4'b1010, 1'b0);
    issue("xor", 4'd6, 8'hF1, 8'hB1, 8'h40, 8'h00, 4'b1000, 1'b0);
    issue("not", 4'd7, 8'hF1, 8'hB1, 8'h0E, 8'h00, 4'b1000, 1'b0);
    issue("shl", 4'd8, 8'h41, 8'h00, 8'h82, 8'h00, 4'b0010, 1'b0);
    issue("shr", 4'd9, 8'h01, 8'h00, 8'h00, 8'h00, 4'b1100, 1'b0);
    issue("adc_c", 4'd1, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1'b0);
    drain();

    // Output stall: result held while out_ready is low
    out_ready = 1'b0;
    issue("add_wrap", 4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("stall.out_valid", 32'(out_valid), 32'd1);
      chk("stall.flags",     32'(flags),     32'b1100);
      chk("stall.in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue("illegal12", 4'd12, 8'h12, 8'h34, 8'h00, 8'h00, 4'b1100, 1'b1);
    issue("add_after_ill", 4'd0, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1'b0);
    drain();

`ifdef ALU_MUL_EN
    out_ready = 1'b0;
    issue("mul", 4'd10, 8'h57, 8'hB1, 8'h27, 8'h3C, 4'b1000, 1'b0);
    chk("mul.busy0", 32'(out_valid), 32'd0);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk);
      #1;
      chk("mul.busy.out_valid", 32'(out_valid), 32'd0);
      chk("mul.busy.in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    chk("mul.latency", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("mul.hold.result_hi", 32'(result_hi), 32'h3C);
      chk("mul.hold.result",    32'(result),    32'h27);
      chk("mul.hold.in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a multiply
    issue("mul_abort", 4'd10, 8'h57, 8'hB1, 8'h27, 8'h3C, 4'b1000, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
`else
    issue("mul_off", 4'd10, 8'h57, 8'hB1, 8'h00, 8'h00, 4'b0000, 1'b1);
    chk("mul_off.latency", 32'(out_valid), 32'd1);
    drain();

    // Reset while a result is held
    out_ready = 1'b0;
    issue("add_abort", 4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1100, 1'b0);
    rst_n = 1'b0;
    #1;
`endif
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.flags",     32'(flags),     32'd0);
    chk("midrst.result",    32'(result),    32'd0);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    issue("illegal_post", 4'd12, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0000, 1'b1);
    issue("adc_post", 4'd1, 8'h10, 8'h20, 8'h30, 8'h00, 4'b0000, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_w.md
Name: alu_seq_w

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Adds valid/ready handshakes on both sides and an internal flags register (C, Z, N, V).
- ADC/SBB take their carry/borrow from the stored C flag.
- Shift ops, plus an optional multi-cycle shift-and-add unsigned multiplier; sits between operand fetch and writeback in the datapath.

Parameters:
- W, 8, operand/result width (>= 4).
- CW, 4, opcode width (fixed encoding below; must be >= 4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept request this cycle.
- op  in  CW  opcode.
- A  in  W  operand A.
- B  in  W  operand B.
- out_valid  out  1  result registered and held.
- out_ready  in  1  consumer accepts result.
- result  out  W  result (low half for MUL).
- result_hi  out  W  high half for MUL, else 0.
- flags  out  4  {C,Z,N,V} after this result.
- err  out  1  illegal opcode flag for this result.

Behaviour:
- Opcodes:
  - 0 ADD: A+B.
  - 1 ADC: A+B+C.
  - 2 SUB: A-B.
  - 3 SBB: A-B-C.
  - 4 AND, 5 OR, 6 XOR.
  - 7 NOT: ~A.
  - 8 SHL: A<<1.
  - 9 SHR: logical A>>1.
  - 10 MUL: unsigned A*B.
  - 11-15 illegal.
- Arithmetic:
  - Computed at W+1 bits.
  - ADD/ADC: C = carry out.
  - SUB/SBB: C = borrow, i.e. 1 when A < B + bin.
  - V = signed overflow for arithmetic ops; V=0 for all other ops.
  - Z = (result==0); N = result[W-1].
- Logic ops: C unchanged.
- SHL/SHR: C = bit shifted out.
- MUL: C = (result_hi != 0); Z computed over the full 2W result.
- Illegal op: result=0, result_hi=0, err=1, flags register unchanged.
- FSM states: IDLE, MUL_RUN, DONE.
- Transitions:
  - IDLE: in_ready=1. On in_valid, latch op/A/B.
    - Single-cycle op: result and flags registered, go to DONE; out_valid rises the next cycle (latency 1).
    - MUL: go to MUL_RUN with counter=0.
  - MUL_RUN: in_ready=0. One shift-and-add step per cycle for W cycles, then DONE; out_valid is asserted W+1 cycles after accept.
  - DONE: out_valid=1; result, result_hi, flags and err are held stable until out_ready.
    - in_ready = out_ready in DONE.
    - out_ready && in_valid: the new op is accepted in the same cycle (back-to-back, throughput 1/cycle for single-cycle ops).
    - out_ready && !in_valid: go to IDLE.
- Flags register:
  - Updates on the cycle the result enters DONE, so a following ADC/SBB sees the new C.
  - Back-to-back dependency is honoured.
- No request is dropped: in_valid while in_ready=0 must be held by the source; the block ignores it.
- Reset (async, any state, including mid-MUL): state=IDLE, out_valid=0, result=0, result_hi=0, flags=0, err=0, counter=0; the partial product is discarded.
- After reset, in_ready=1 in the first cycle.

Optional Feature:
- ALU_MUL_EN defined: MUL implemented as above.
- Not defined: opcode 10 is illegal (err=1, results 0, flags unchanged, latency 1); no multiplier datapath or MUL_RUN state is synthesised.

Test Plan:
- Reset, then W=8, ADD A=0x57 B=0xB1 -> one cycle later out_valid=1, result=0x08, flags C=1 Z=0 N=0 V=0.
- Immediately follow with ADC 0x57,0xB1 (back-to-back, out_ready=1) -> result=0x09, C=1.
- SUB 0x57,0xB1 -> result=0xA6, C(borrow)=1, N=1; then SBB same operands -> 0xA5.
- AND/OR/XOR/NOT on 0xF1,0xB1 -> 0xB1/0xF1/0x40/0x0E, C held from previous op, V=0.
- With ALU_MUL_EN: MUL 0x57*0xB1 -> out_valid after 9 cycles, result_hi=0x3C, result=0x27, C=1; in_ready=0 throughout; out_ready held low 3 cycles -> outputs stable.
- Assert rst_n low mid-MUL (cycle 4) -> out_valid=0, flags=0 immediately; opcode 12 -> err=1, result=0, flags unchanged.
